// File: rtl/read_resp_router.sv
// AXI read-data return router: steers R beats from the slave to the
// master that owns the oldest outstanding burst, tracked in an ID FIFO.
module read_resp_router #(
  parameter int Masters_Num       = 2,
  parameter int Masters_ID_Size   = $clog2(Masters_Num),
  parameter int Data_Width        = 32,
  parameter int Outstanding_Depth = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       AR_Issued,
  input  logic [Masters_ID_Size-1:0] AR_Master_ID,
  output logic                       Outstanding_Full,
  output logic [$clog2(Outstanding_Depth+1)-1:0] Outstanding_Count,
  output logic                       Unexpected_Resp,
  input  logic                       M_AXI_rvalid,
  input  logic [Data_Width-1:0]      M_AXI_rdata,
  input  logic [1:0]                 M_AXI_rresp,
  input  logic                       M_AXI_rlast,
  output logic                       M_AXI_rready,
  output logic                       S00_AXI_rvalid,
  output logic [Data_Width-1:0]      S00_AXI_rdata,
  output logic [1:0]                 S00_AXI_rresp,
  output logic                       S00_AXI_rlast,
  input  logic                       S00_AXI_rready,
  output logic                       S01_AXI_rvalid,
  output logic [Data_Width-1:0]      S01_AXI_rdata,
  output logic [1:0]                 S01_AXI_rresp,
  output logic                       S01_AXI_rlast,
  input  logic                       S01_AXI_rready
);

  localparam int PW = $clog2(Outstanding_Depth);
  localparam int CW = $clog2(Outstanding_Depth+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(Outstanding_Depth);

  logic [Masters_ID_Size-1:0] fifo_q [Outstanding_Depth];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          unexp_q, unexp_d;

  logic [Masters_ID_Size-1:0] head;
  logic nonempty;
  logic sel0, sel1;
  logic push, pop;

  assign head     = fifo_q[rd_ptr_q];
  assign nonempty = (count_q != '0);
  assign sel0     = nonempty && (head == Masters_ID_Size'(0));
  assign sel1     = nonempty && (head == Masters_ID_Size'(1));

  assign S00_AXI_rvalid = M_AXI_rvalid && sel0;
  assign S01_AXI_rvalid = M_AXI_rvalid && sel1;
  assign S00_AXI_rdata  = M_AXI_rdata;
  assign S01_AXI_rdata  = M_AXI_rdata;
  assign S00_AXI_rresp  = M_AXI_rresp;
  assign S01_AXI_rresp  = M_AXI_rresp;
  assign S00_AXI_rlast  = M_AXI_rlast;
  assign S01_AXI_rlast  = M_AXI_rlast;

  assign M_AXI_rready = (sel0 && S00_AXI_rready)
                     || (sel1 && S01_AXI_rready);

  assign pop  = M_AXI_rvalid && M_AXI_rready && M_AXI_rlast;
  assign push = AR_Issued && ((count_q < DEPTH_C) || pop);

  assign Outstanding_Full  = (count_q == DEPTH_C);
  assign Outstanding_Count = count_q;
  assign Unexpected_Resp   = unexp_q;

  // Next-state for pointers, occupancy and the sticky error flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unexp_d  = unexp_q | (M_AXI_rvalid && !nonempty);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      unexp_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      unexp_q  <= unexp_d;
    end
  end

  // ID storage; contents are irrelevant while count is zero
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < Outstanding_Depth; i++)
        fifo_q[i] <= '0;
    end else if (push) begin
      fifo_q[wr_ptr_q] <= AR_Master_ID;
    end
  end

endmodule

// File: tb/tb_read_resp_router.sv
// Directed bench for read_resp_router: routing, ordering,
// backpressure, full-push/pop and mid-burst reset.
module tb_read_resp_router;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ar_issued;
  logic [0:0]  ar_id;
  logic        full;
  logic [2:0]  cnt;
  logic        unexp;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        m_rready;
  logic        s0_rvalid, s0_rlast, s0_rready;
  logic [31:0] s0_rdata;
  logic [1:0]  s0_rresp;
  logic        s1_rvalid, s1_rlast, s1_rready;
  logic [31:0] s1_rdata;
  logic [1:0]  s1_rresp;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  read_resp_router dut (
    .ACLK              (clk),
    .ARESETN           (rst_n),
    .AR_Issued         (ar_issued),
    .AR_Master_ID      (ar_id),
    .Outstanding_Full  (full),
    .Outstanding_Count (cnt),
    .Unexpected_Resp   (unexp),
    .M_AXI_rvalid      (m_rvalid),
    .M_AXI_rdata       (m_rdata),
    .M_AXI_rresp       (m_rresp),
    .M_AXI_rlast       (m_rlast),
    .M_AXI_rready      (m_rready),
    .S00_AXI_rvalid    (s0_rvalid),
    .S00_AXI_rdata     (s0_rdata),
    .S00_AXI_rresp     (s0_rresp),
    .S00_AXI_rlast     (s0_rlast),
    .S00_AXI_rready    (s0_rready),
    .S01_AXI_rvalid    (s1_rvalid),
    .S01_AXI_rdata     (s1_rdata),
    .S01_AXI_rresp     (s1_rresp),
    .S01_AXI_rlast     (s1_rlast),
    .S01_AXI_rready    (s1_rready)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // owners expected after the full push/pop: 1,0,1,1
  logic [0:0] exp_own [4];

  initial begin
    exp_own[0] = 1'b1;
    exp_own[1] = 1'b0;
    exp_own[2] = 1'b1;
    exp_own[3] = 1'b1;

    rst_n = 1'b0;
    ar_issued = 1'b0; ar_id = 1'b0;
    m_rvalid = 1'b0; m_rdata = '0;
    m_rresp = 2'b00; m_rlast = 1'b0;
    s0_rready = 1'b0; s1_rready = 1'b0;
    #12;
    check("rst_cnt", cnt, 0);
    check("rst_full", full, 0);
    check("rst_unexp", unexp, 0);
    check("rst_mrdy", m_rready, 0);
    check("rst_s0v", s0_rvalid, 0);
    check("rst_s1v", s1_rvalid, 0);
    rst_n = 1'b1;
    step();

    // beat while empty
    m_rvalid = 1'b1;
    s0_rready = 1'b1; s1_rready = 1'b1;
    #1;
    check("empty_mrdy", m_rready, 0);
    check("empty_s0v", s0_rvalid, 0);
    step();
    check("empty_unexp", unexp, 1);
    m_rvalid = 1'b0;

    // single burst to M1
    ar_issued = 1'b1; ar_id = 1'b1;
    step();
    ar_issued = 1'b0;
    check("b1_cnt1", cnt, 1);
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1;
      m_rdata = 32'hA000_0000 + b;
      m_rlast = (b == 3);
      #1;
      check("b1_s1v", s1_rvalid, 1);
      check("b1_s0v", s0_rvalid, 0);
      check("b1_mrdy", m_rready, 1);
      check("b1_data", s1_rdata, 32'hA000_0000 + b);
      check("b1_s0data", s0_rdata, 32'hA000_0000 + b);
      step();
      if (b < 3) check("b1_cnt_mid", cnt, 1);
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    check("b1_cnt0", cnt, 0);

    // fill with 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      ar_issued = 1'b1; ar_id = 1'(i & 1);
      step();
      check("fill_cnt", cnt, i + 1);
    end
    check("fill_full", full, 1);
    // push while full without pop is dropped
    ar_id = 1'b0;
    step();
    ar_issued = 1'b0;
    check("drop_cnt", cnt, 4);

    // backpressure on head (M0)
    s0_rready = 1'b0; s1_rready = 1'b1;
    m_rvalid = 1'b1; m_rlast = 1'b1;
    m_rdata = 32'h0000_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_mrdy", m_rready, 0);
      check("bp_s0v", s0_rvalid, 1);
      check("bp_s1v", s1_rvalid, 0);
      step();
      check("bp_cnt", cnt, 4);
    end

    // release with simultaneous push of ID 1 at full
    s0_rready = 1'b1;
    ar_issued = 1'b1; ar_id = 1'b1;
    #1;
    check("pp_mrdy", m_rready, 1);
    step();
    ar_issued = 1'b0;
    check("pp_cnt", cnt, 4);
    check("pp_full", full, 1);

    // drain 2-beat bursts, SLVERR on first beat
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 2; b++) begin
        m_rvalid = 1'b1;
        m_rlast = (b == 1);
        m_rresp = (b == 0) ? 2'b10 : 2'b00;
        m_rdata = 32'h100 * k + b;
        #1;
        check("dr_s0v", s0_rvalid, exp_own[k] == 1'b0);
        check("dr_s1v", s1_rvalid, exp_own[k] == 1'b1);
        check("dr_resp", s0_rresp, m_rresp);
        check("dr_rlast", s1_rlast, b == 1);
        step();
      end
      check("dr_cnt", cnt, 3 - k);
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    check("dr_full", full, 0);

    // reset mid-burst with 2 outstanding
    ar_issued = 1'b1; ar_id = 1'b0;
    step();
    ar_id = 1'b1;
    step();
    ar_issued = 1'b0;
    check("mr_cnt2", cnt, 2);
    m_rvalid = 1'b1; m_rlast = 1'b0;
    #1;
    check("mr_s0v_pre", s0_rvalid, 1);
    step();
    rst_n = 1'b0;
    #1;
    check("mr_cnt0", cnt, 0);
    check("mr_s0v", s0_rvalid, 0);
    check("mr_s1v", s1_rvalid, 0);
    check("mr_mrdy", m_rready, 0);
    check("mr_unexp0", unexp, 0);
    #2;
    rst_n = 1'b1;
    step();
    check("mr_unexp1", unexp, 1);
    m_rvalid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
